score_keeper: RTL and testbench

Per-player and global high-score tracker that sits directly downstream of `GameController`. It consumes each end-of-game score request (`score_req`, `score`, `player_id`, `isGuest`) and returns the `valid`, `PersonalBest_in` and `GlobalWinner_in` strobes that the controller waits on. It also exposes the current global record, as a binary value and as BCD digits, for the seven-segment display path.

---
 rtl/score_keeper.sv | 142 ++++++++++++++
 tb/tb_score_keeper.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: per-player and global high-score tracker.
// Each request walks a fixed five-state sequence (IDLE, CAPTURE, COMPARE,
// COMMIT, RESPOND), so the response latency is always four cycles. The global
// record is also kept as registered BCD digits for the display path.
module score_keeper #(
  parameter  int NUM_PLAYERS = 8,
  parameter  int SCORE_W     = 7,
  parameter  int MAX_SCORE   = 99,
  localparam int ID_W        = $clog2(NUM_PLAYERS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               score_req,
  input  logic [SCORE_W-1:0] score,
  input  logic [ID_W-1:0]    player_id,
  input  logic               isGuest,
  input  logic               clear_scores,
  output logic               busy,
  output logic               valid,
  output logic               PersonalBest_in,
  output logic               GlobalWinner_in,
  output logic [SCORE_W-1:0] global_score,
  output logic [ID_W-1:0]    global_id,
  output logic [3:0]         global_tens,
  output logic [3:0]         global_ones
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    COMPARE = 3'd2,
    COMMIT  = 3'd3,
    RESPOND = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] SAT_SCORE = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] ZERO_SCORE = {SCORE_W{1'b0}};
  localparam logic [ID_W-1:0]    ZERO_ID    = {ID_W{1'b0}};

  state_t             state_r;
  logic [SCORE_W-1:0] best_r [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_lat_r;
  logic [SCORE_W-1:0] sat_r;
  logic [SCORE_W-1:0] best_rd_r;
  logic [ID_W-1:0]    id_lat_r;
  logic               guest_r;
  logic               pb_r;
  logic               gw_r;

  // Split a score (at most MAX_SCORE, so two decimal digits) into {tens, ones}.
  function automatic logic [7:0] to_bcd(input logic [SCORE_W-1:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / SCORE_W'(10));
    ones = 4'(v % SCORE_W'(10));
    return {tens, ones};
  endfunction

  // Request sequencer: owns the score table, the global record and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        best_r[i] <= ZERO_SCORE;
      end
      score_lat_r     <= ZERO_SCORE;
      sat_r           <= ZERO_SCORE;
      best_rd_r       <= ZERO_SCORE;
      id_lat_r        <= ZERO_ID;
      guest_r         <= 1'b0;
      pb_r            <= 1'b0;
      gw_r            <= 1'b0;
      busy            <= 1'b0;
      valid           <= 1'b0;
      PersonalBest_in <= 1'b0;
      GlobalWinner_in <= 1'b0;
      global_score    <= ZERO_SCORE;
      global_id       <= ZERO_ID;
      global_tens     <= 4'd0;
      global_ones     <= 4'd0;
    end else begin
      // valid is a single-cycle strobe; only COMMIT raises it.
      valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (clear_scores) begin
            // Wipe has priority over a simultaneous request; flags are kept.
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              best_r[i] <= ZERO_SCORE;
            end
            global_score <= ZERO_SCORE;
            global_id    <= ZERO_ID;
            global_tens  <= 4'd0;
            global_ones  <= 4'd0;
          end else if (score_req) begin
            score_lat_r <= score;
            id_lat_r    <= player_id;
            guest_r     <= isGuest;
            busy        <= 1'b1;
            state_r     <= CAPTURE;
          end else begin
            state_r <= IDLE;
          end
        end
        CAPTURE: begin
          sat_r     <= (score_lat_r > SAT_SCORE) ? SAT_SCORE : score_lat_r;
          best_rd_r <= best_r[id_lat_r];
          state_r   <= COMPARE;
        end
        COMPARE: begin
          // Strict compares: ties keep the earlier holder, and 0 never wins.
          pb_r    <= !guest_r && (sat_r > best_rd_r);
          gw_r    <= !guest_r && (sat_r > global_score);
          state_r <= COMPARE == state_r ? COMMIT : IDLE;
        end
        COMMIT: begin
          if (pb_r) begin
            best_r[id_lat_r] <= sat_r;
          end
          if (gw_r) begin
            global_score <= sat_r;
            global_id    <= id_lat_r;
            {global_tens, global_ones} <= to_bcd(sat_r);
          end
          valid           <= 1'b1;
          PersonalBest_in <= pb_r;
          GlobalWinner_in <= gw_r;
          state_r         <= RESPOND;
        end
        RESPOND: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios from the plan plus
// randomized traffic, checked against a plain-arithmetic high-score model.
module tb_score_keeper;

  logic       clk;
  logic       rst;
  logic       score_req;
  logic [6:0] score;
  logic [2:0] player_id;
  logic       isGuest;
  logic       clear_scores;
  logic       busy;
  logic       valid;
  logic       PersonalBest_in;
  logic       GlobalWinner_in;
  logic [6:0] global_score;
  logic [2:0] global_id;
  logic [3:0] global_tens;
  logic [3:0] global_ones;

  int checks;
  int errors;

  // Reference model state
  int   best_m [8];
  int   gs_m;
  int   gid_m;
  logic last_pb;
  logic last_gw;

  score_keeper dut (
    .clk             (clk),
    .rst             (rst),
    .score_req       (score_req),
    .score           (score),
    .player_id       (player_id),
    .isGuest         (isGuest),
    .clear_scores    (clear_scores),
    .busy            (busy),
    .valid           (valid),
    .PersonalBest_in (PersonalBest_in),
    .GlobalWinner_in (GlobalWinner_in),
    .global_score    (global_score),
    .global_id       (global_id),
    .global_tens     (global_tens),
    .global_ones     (global_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) best_m[i] = 0;
    gs_m  = 0;
    gid_m = 0;
  endtask

  task automatic model_req(input int id, input int sc, input bit g,
                           output logic epb, output logic egw);
    int s;
    s   = (sc > 99) ? 99 : sc;
    epb = !g && (s > best_m[id]);
    egw = !g && (s > gs_m);
    if (epb) best_m[id] = s;
    if (egw) begin
      gs_m  = s;
      gid_m = id;
    end
    last_pb = epb;
    last_gw = egw;
  endtask

  // Drives one request and reports what the DUT returned.
  task automatic send_req(input int id, input int sc, input bit g,
                          output int lat, output logic pb, output logic gw,
                          output logic v_after, output logic b_after);
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 20) begin
      checks++; errors++;
      $display("FAIL idle_wait: busy=%b required 0", busy);
    end
    @(negedge clk);
    player_id = 3'(id);
    score     = 7'(sc);
    isGuest   = g;
    score_req = 1'b1;
    @(posedge clk); #1;
    score_req = 1'b0;
    lat = 1;
    while (valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    pb = PersonalBest_in;
    gw = GlobalWinner_in;
    @(posedge clk); #1;
    v_after = valid;
    b_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, valid, PersonalBest_in, GlobalWinner_in} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000",
               {busy, valid, PersonalBest_in, GlobalWinner_in});
    end
    checks++;
    if ({global_score, global_id, global_tens, global_ones} !== 18'd0) begin
      errors++;
      $display("FAIL reset_global: score=%0d id=%0d digits=%0d/%0d required 0",
               global_score, global_id, global_tens, global_ones);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    last_pb = 1'b0;
    last_gw = 1'b0;
  endtask

  // One checked request: latency, strobe shape, flags and global record.
  task automatic checked_req(input string name, input int id, input int sc, input bit g);
    int   lat;
    logic pb, gw, va, ba, epb, egw;
    send_req(id, sc, g, lat, pb, gw, va, ba);
    model_req(id, sc, g, epb, egw);
    checks++;
    if (lat !== 4 || va !== 1'b0 || ba !== 1'b0) begin
      errors++;
      $display("FAIL %s_timing: latency=%0d valid_after=%b busy_after=%b required 4/0/0",
               name, lat, va, ba);
    end
    checks++;
    if (pb !== epb || gw !== egw) begin
      errors++;
      $display("FAIL %s_flags: pb=%b gw=%b required pb=%b gw=%b", name, pb, gw, epb, egw);
    end
    checks++;
    if (global_score !== 7'(gs_m) || global_id !== 3'(gid_m) ||
        global_tens !== 4'(gs_m / 10) || global_ones !== 4'(gs_m % 10)) begin
      errors++;
      $display("FAIL %s_global: score=%0d id=%0d digits=%0d/%0d required %0d/%0d digits %0d/%0d",
               name, global_score, global_id, global_tens, global_ones,
               gs_m, gid_m, gs_m / 10, gs_m % 10);
    end
  endtask

  task automatic test_basic();
    checked_req("first_45", 2, 45, 1'b0);   // pb=1 gw=1, record 45 by id 2
    checked_req("tie_45", 5, 45, 1'b0);     // pb=1 gw=0, id stays 2
    checked_req("lower_30", 2, 30, 1'b0);   // both 0
    checked_req("repeat_44", 2, 44, 1'b0);  // best[2] still 45: both 0
  endtask

  task automatic test_guest_saturate();
    checked_req("guest_99", 3, 99, 1'b1);   // both 0, record unchanged
    checked_req("sat_120", 3, 120, 1'b0);   // saturates to 99, both 1
    checked_req("sat_127", 6, 127, 1'b0);   // 99 ties global: pb=1 gw=0
    checked_req("zero", 7, 0, 1'b0);        // 0 never sets a flag
  endtask

  task automatic test_ignore_busy();
    int   vc, bc;
    logic pb, gw, epb, egw;
    vc = 0; bc = 0; pb = 1'bx; gw = 1'bx;
    @(negedge clk);
    player_id = 3'd4; score = 7'd50; isGuest = 1'b0; score_req = 1'b1;
    @(posedge clk); #1;
    score_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (busy === 1'b1) bc++;
      if (valid === 1'b1) begin
        vc++;
        pb = PersonalBest_in;
        gw = GlobalWinner_in;
      end
      if (k == 1) begin
        score_req = 1'b1; player_id = 3'd6; score = 7'd98;
      end
      if (k == 2) score_req = 1'b0;
      @(posedge clk); #1;
    end
    model_req(4, 50, 1'b0, epb, egw);
    checks++;
    if (vc !== 1 || bc !== 4) begin
      errors++;
      $display("FAIL busy_ignore_counts: valid_pulses=%0d busy_cycles=%0d required 1/4", vc, bc);
    end
    checks++;
    if (pb !== epb || gw !== egw || global_score !== 7'(gs_m)) begin
      errors++;
      $display("FAIL busy_ignore_result: pb=%b gw=%b score=%0d required %b/%b/%0d",
               pb, gw, global_score, epb, egw, gs_m);
    end
  endtask

  task automatic test_clear();
    int vc, bc;
    vc = 0; bc = 0;
    @(negedge clk);
    clear_scores = 1'b1; score_req = 1'b1; player_id = 3'd7; score = 7'd60; isGuest = 1'b0;
    @(posedge clk); #1;
    clear_scores = 1'b0; score_req = 1'b0;
    model_clear();
    checks++;
    if ({global_score, global_id, global_tens, global_ones} !== 18'd0) begin
      errors++;
      $display("FAIL clear_global: score=%0d id=%0d digits=%0d/%0d required 0",
               global_score, global_id, global_tens, global_ones);
    end
    checks++;
    if (PersonalBest_in !== last_pb || GlobalWinner_in !== last_gw) begin
      errors++;
      $display("FAIL clear_keeps_flags: pb=%b gw=%b required %b/%b",
               PersonalBest_in, GlobalWinner_in, last_pb, last_gw);
    end
    for (int k = 0; k < 8; k++) begin
      if (valid === 1'b1) vc++;
      if (busy === 1'b1) bc++;
      @(posedge clk); #1;
    end
    checks++;
    if (vc !== 0 || bc !== 0) begin
      errors++;
      $display("FAIL clear_wins: valid_pulses=%0d busy_cycles=%0d required 0/0", vc, bc);
    end
    checked_req("after_clear_1", 0, 1, 1'b0);  // both 1
  endtask

  task automatic test_rst_abort();
    int vc;
    vc = 0;
    @(negedge clk);
    player_id = 3'd1; score = 7'd80; isGuest = 1'b0; score_req = 1'b1;
    @(posedge clk); #1;               // after E0: CAPTURE
    score_req = 1'b0;
    if (valid === 1'b1) vc++;
    @(posedge clk); #1;               // after E1: COMPARE
    if (valid === 1'b1) vc++;
    rst = 1'b1;
    @(posedge clk); #1;               // reset sampled in COMPARE
    rst = 1'b0;
    checks++;
    if ({busy, valid, PersonalBest_in, GlobalWinner_in, global_score,
         global_id, global_tens, global_ones} !== 22'd0) begin
      errors++;
      $display("FAIL rst_abort_outputs: busy=%b valid=%b pb=%b gw=%b score=%0d id=%0d digits=%0d/%0d required all 0",
               busy, valid, PersonalBest_in, GlobalWinner_in, global_score,
               global_id, global_tens, global_ones);
    end
    for (int k = 0; k < 6; k++) begin
      if (valid === 1'b1) vc++;
      @(posedge clk); #1;
    end
    checks++;
    if (vc !== 0) begin
      errors++;
      $display("FAIL rst_abort_valid: valid_pulses=%0d required 0", vc);
    end
    model_clear();
    last_pb = 1'b0;
    last_gw = 1'b0;
    checked_req("after_rst_1", 1, 1, 1'b0);  // best[1]=0 so pb=1
  endtask

  task automatic test_back_to_back();
    checked_req("b2b_a", 2, 10, 1'b0);
    checked_req("b2b_b", 3, 20, 1'b0);
    checked_req("b2b_c", 2, 15, 1'b0);
    checked_req("b2b_d", 3, 20, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(7, 0) == 0) begin
        @(negedge clk);
        clear_scores = 1'b1;
        @(posedge clk); #1;
        clear_scores = 1'b0;
        model_clear();
        checks++;
        if (global_score !== 7'd0 || global_id !== 3'd0) begin
          errors++;
          $display("FAIL rand_clear: score=%0d id=%0d required 0/0", global_score, global_id);
        end
      end else begin
        checked_req("rand", int'($urandom_range(7, 0)), int'($urandom_range(127, 0)),
                    $urandom_range(3, 0) == 0);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    score_req = 1'b0;
    score = 7'd0;
    player_id = 3'd0;
    isGuest = 1'b0;
    clear_scores = 1'b0;
    test_reset();
    test_basic();
    test_guest_saturate();
    test_ignore_busy();
    test_clear();
    test_rst_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
